// File: rtl/clk_copy_mon_pkg.sv
// Shared types and constants for the copied-clock monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_copy_mon_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clk_copy_mon_sync_cell.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: DEPTH clk cycles from input change to q_o.
// Backpressure: none; free-running.
module sync_cell #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/clk_copy_mon.sv
// Copied-clock monitor: measures edge-to-edge intervals and tracks lock/loss.
// Latency: SYNC_STAGES+1 cycles input-to-event, outputs registered one cycle after the event.
// Backpressure: none. Optional error counter enabled by defining CLK_COPY_MON_ERRCNT_EN.
module clk_copy_mon
    import clk_copy_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_HALF    = 4,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_copy_in,
    input  logic             enable,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] period_meas
`ifdef CLK_COPY_MON_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    // Window of acceptable intervals, held at 32 bits so EXP_HALF+TOL may exceed 255.
    localparam logic [31:0]      GOOD_LO = 32'(EXP_HALF - TOL);
    localparam logic [31:0]      GOOD_HI = 32'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_CNT);

    logic             copy_s;
    logic             copy_edge_q;
    logic             evt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ivl;
    logic             good;
    logic             timeout;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             locked_q;
    logic             lost_q, lost_d;

    sync_cell #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (clk_copy_in),
        .q_o   (copy_s)
    );

    // Remember the previous synchronized level so either edge can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_edge_q <= 1'b0;
        end else begin
            copy_edge_q <= copy_s;
        end
    end

    assign evt = copy_s ^ copy_edge_q;

    // Counter holds cycles since the last event; the interval includes the event cycle.
    assign cnt_d   = evt ? '0 : sat_inc(cnt_q);
    assign ivl     = sat_inc(cnt_q);
    assign good    = ({{(32-CNT_W){1'b0}}, ivl} >= GOOD_LO) &&
                     ({{(32-CNT_W){1'b0}}, ivl} <= GOOD_HI);
    assign timeout = (cnt_q == TO_V);

    // Interval counter, restarted by every event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic; disable wins over any event seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        first_d    = first_q;
        period_d   = period_q;
        lost_d     = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, LOST: begin
                    // Re-arm: the next edge only marks a starting point.
                    state_d    = ACQ;
                    good_cnt_d = '0;
                    first_d    = 1'b1;
                end
                ACQ: begin
                    if (evt) begin
                        if (first_q) begin
                            first_d = 1'b0;
                        end else begin
                            period_d = ivl;
                            if (good) begin
                                good_cnt_d = good_cnt_q + 1'b1;
                                if (good_cnt_q + 1'b1 == LOCK_V) begin
                                    state_d = LOCKED;
                                end
                            end else begin
                                good_cnt_d = '0;
                            end
                        end
                    end else if (timeout) begin
                        good_cnt_d = '0;
                        first_d    = 1'b1;
                    end
                end
                LOCKED: begin
                    if (evt) begin
                        period_d = ivl;
                        if (!good) begin
                            state_d = LOST;
                            lost_d  = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d = LOST;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, measurement and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            good_cnt_q <= '0;
            first_q    <= 1'b0;
            period_q   <= '0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            first_q    <= first_d;
            period_q   <= period_d;
            locked_q   <= (state_d == LOCKED);
            lost_q     <= lost_d;
        end
    end

    assign locked      = locked_q;
    assign lost        = lost_q;
    assign period_meas = period_q;

`ifdef CLK_COPY_MON_ERRCNT_EN
    logic             err_inc;
    logic [CNT_W-1:0] err_q;

    // Bad measured intervals and timeouts while monitoring; the arming edge is never judged.
    assign err_inc = enable &&
                     (((state_q == ACQ) && ((evt && !first_q && !good) || (!evt && timeout))) ||
                      ((state_q == LOCKED) && (evt ? !good : timeout)));

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_inc) begin
            err_q <= sat_inc(err_q);
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_clk_copy_mon.sv
// Self-checking bench for clk_copy_mon: directed phases with randomized intervals.
// Latency: reference model tracks event times and applies the lock rules per clk.
// Backpressure: n/a.
module tb_clk_copy_mon;

    localparam int S      = 2;
    localparam int EXP    = 4;
    localparam int TOLV   = 1;
    localparam int LOCKN  = 8;
    localparam int TOV    = 16;

    logic       clk;
    logic       rst_n;
    logic       clk_copy_in;
    logic       enable;
    logic       locked;
    logic       lost;
    logic [7:0] period_meas;
`ifdef CLK_COPY_MON_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    clk_copy_mon #(
        .SYNC_STAGES (S),
        .EXP_HALF    (EXP),
        .TOL         (TOLV),
        .LOCK_CNT    (LOCKN),
        .TIMEOUT     (TOV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_copy_in (clk_copy_in),
        .enable      (enable),
        .locked      (locked),
        .lost        (lost),
        .period_meas (period_meas)
`ifdef CLK_COPY_MON_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: modes 0 idle, 1 acquiring, 2 locked, 3 lost.
    int   m_mode, m_run, m_period, m_err, m_last, n;
    bit   m_first, m_locked, m_lost;
    logic h [0:7];
    logic cin_r;
    logic en_r;
    int   lost_seen, ev_cnt, ev_at_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Model one rising clk edge given the input history and enable.
    task automatic model_edge();
        bit ev, good, to;
        int age, cnt, ivl;
        ev   = (h[S] !== h[S+1]);
        age  = n - m_last - 1;
        cnt  = (age > 255) ? 255 : age;
        ivl  = (cnt + 1 > 255) ? 255 : cnt + 1;
        good = (ivl >= EXP - TOLV) && (ivl <= EXP + TOLV);
        to   = (cnt == TOV);
        m_lost = 1'b0;
        if (!en_r) begin
            m_mode = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            m_mode = 1; m_run = 0; m_first = 1'b1;
        end else if (m_mode == 1) begin
            if (ev) begin
                if (m_first) m_first = 1'b0;
                else begin
                    m_period = ivl;
                    if (good) begin
                        m_run++;
                        if (m_run == LOCKN) m_mode = 2;
                    end else begin
                        m_run = 0; m_err++;
                    end
                end
            end else if (to) begin
                m_run = 0; m_first = 1'b1; m_err++;
            end
        end else begin
            if (ev) begin
                m_period = ivl;
                if (!good) begin m_mode = 3; m_lost = 1'b1; m_err++; end
            end else if (to) begin
                m_mode = 3; m_lost = 1'b1; m_err++;
            end
        end
        if (m_err > 255) m_err = 255;
        m_locked = (m_mode == 2);
        if (ev) begin
            m_last = n;
            ev_cnt++;
        end
        n++;
    endtask

    // Drive one cycle's inputs at a falling edge, then check at the next falling edge.
    task automatic step(input logic cin_v);
        clk_copy_in = cin_v;
        enable      = en_r;
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        h[0] = cin_v;
        model_edge();
        @(negedge clk);
        chk("locked", {31'd0, locked}, {31'd0, m_locked});
        chk("lost", {31'd0, lost}, {31'd0, m_lost});
        chk("period_meas", {24'd0, period_meas}, m_period);
`ifdef CLK_COPY_MON_ERRCNT_EN
        chk("err_cnt", {24'd0, err_cnt}, m_err);
`endif
        if (lost === 1'b1) lost_seen++;
        if (locked === 1'b1 && ev_at_lock < 0) ev_at_lock = ev_cnt;
    endtask

    // Toggle the copied clock, then hold it for a total of len cycles.
    task automatic half(input int len);
        cin_r = ~cin_r;
        repeat (len) step(cin_r);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0; clk_copy_in = 1'b0; enable = 1'b0; cin_r = 1'b0; en_r = 1'b0;
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_lost", {31'd0, lost}, 32'd0);
        chk("rst_period", {24'd0, period_meas}, 32'd0);
`ifdef CLK_COPY_MON_ERRCNT_EN
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        repeat (S + 3) @(negedge clk);
        for (int i = 0; i < 8; i++) h[i] = 1'b0;
        m_mode = 0; m_run = 0; m_first = 1'b0; m_period = 0; m_err = 0;
        m_locked = 1'b0; m_lost = 1'b0; m_last = n - 1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; clk_copy_in = 1'b0; enable = 1'b0;
        n = 0; cin_r = 1'b0; en_r = 1'b0;
        lost_seen = 0; ev_cnt = 0; ev_at_lock = -1;
        do_reset();

        // Disabled: edges are ignored.
        repeat (4) half(3);

        // Nominal acquisition: arming edge plus eight good intervals.
        en_r = 1'b1; ev_cnt = 0; ev_at_lock = -1;
        repeat (12) half(4);
        chk("lock_edges", ev_at_lock, 32'd9);
        chk("lock_period", {24'd0, period_meas}, 32'd4);
        chk("lock_held", {31'd0, locked}, 32'd1);

        // Random intervals inside tolerance keep lock.
        lost_seen = 0;
        repeat (30) half(int'($urandom_range(5, 3)));
        chk("tol_no_lost", lost_seen, 32'd0);
        chk("tol_locked", {31'd0, locked}, 32'd1);

        // One long interval breaks lock.
        lost_seen = 0;
        half(6);
        half(4);
        chk("long_period", {24'd0, period_meas}, 32'd6);
        chk("long_lost", lost_seen, 32'd1);
        chk("long_unlocked", {31'd0, locked}, 32'd0);
        repeat (12) half(4);
        chk("relock1", {31'd0, locked}, 32'd1);

        // Stopped clock times out.
        lost_seen = 0;
        repeat (30) step(cin_r);
        chk("to_lost", lost_seen, 32'd1);
        chk("to_unlocked", {31'd0, locked}, 32'd0);
        repeat (12) half(4);
        chk("relock2", {31'd0, locked}, 32'd1);

        // Disable drops lock quietly; re-enable needs nine edges.
        lost_seen = 0; en_r = 1'b0;
        repeat (3) half(4);
        chk("dis_no_lost", lost_seen, 32'd0);
        chk("dis_unlocked", {31'd0, locked}, 32'd0);
        en_r = 1'b1; ev_cnt = 0; ev_at_lock = -1;
        repeat (12) half(4);
        chk("reen_edges", ev_at_lock, 32'd9);

        // Random intervals, timeouts and enable toggling.
        repeat (150) begin
            int r;
            if ($urandom_range(19, 0) == 0) en_r = ~en_r;
            r = int'($urandom_range(9, 0));
            if (r == 0) half(20);
            else half(2 + (r % 7));
        end

        // Reset while locked clears everything immediately.
        en_r = 1'b1;
        repeat (12) half(4);
        chk("pre_rst_locked", {31'd0, locked}, 32'd1);
        do_reset();

`ifdef CLK_COPY_MON_ERRCNT_EN
        en_r = 1'b1;
        repeat (4) half(7);
        chk("err_three", {24'd0, err_cnt}, 32'd3);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_copy_mon.md
CLK_COPY_MON -- requirements
Module: clk_copy_mon

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for clk_copy_in, legal range 2..4.
REQ-002 SHALL have parameter EXP_HALF, default 4: expected clk cycles between consecutive clk_copy_in edges, legal range 2..200.
REQ-003 SHALL have parameter TOL, default 1: allowed +/- deviation of a measured interval, legal range 0..EXP_HALF-1.
REQ-004 SHALL have parameter LOCK_CNT, default 8: consecutive good intervals required to lock, legal range 1..255.
REQ-005 SHALL have parameter TIMEOUT, default 16: clk cycles without an edge that count as loss, legal range EXP_HALF+TOL+1..254.
REQ-006 SHALL have port clk, input, 1 bit: sampling clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port clk_copy_in, input, 1 bit: monitored copied clock, asynchronous to clk.
REQ-009 SHALL have port enable, input, 1 bit: monitor enable, synchronous to clk.
REQ-010 SHALL have port locked, output, 1 bit: copied clock within tolerance.
REQ-011 SHALL have port lost, output, 1 bit: one-cycle pulse on loss of lock.
REQ-012 SHALL have port period_meas, output, 8 bits: last measured edge interval in clk cycles.
REQ-013 SHALL have port err_cnt, output, 8 bits: error counter, present only when the macro in REQ-027 is defined.

Function
REQ-014 SHALL pass clk_copy_in through SYNC_STAGES flops, then a one-flop edge detector; either edge is an event.
REQ-015 SHALL keep an 8-bit interval counter: cleared to 0 on an event, otherwise incremented, saturating at 255.
REQ-016 SHALL form the interval on an event as counter+1 (saturating at 255), load it into period_meas, and mark it good when |interval-EXP_HALF| <= TOL.
REQ-017 SHALL implement states IDLE, ACQ, LOCKED and LOST.
REQ-018 SHALL move IDLE->ACQ when enable=1, clear good_cnt, and set the first-edge flag.
REQ-019 In ACQ, the first event after entry SHALL only restart the counter and SHALL NOT update period_meas.
REQ-020 In ACQ, each later good event SHALL increment good_cnt, and a bad event SHALL clear it.
REQ-021 In ACQ, reaching LOCK_CNT good intervals SHALL move to LOCKED, with locked=1 from the following cycle.
REQ-022 In ACQ, counter==TIMEOUT SHALL clear good_cnt and set the first-edge flag, with no lost pulse.
REQ-023 In LOCKED, a bad event or counter==TIMEOUT SHALL move to LOST; lost=1 for exactly one cycle and locked=0 on the same cycle.
REQ-024 LOST SHALL move to ACQ on the next cycle, re-arming as on IDLE exit.
REQ-025 enable=0 SHALL force IDLE on the next edge from any state, with locked=0; lost SHALL NOT pulse on disable; enable has priority over simultaneous events.

Reset
REQ-026 On rst_n=0, all synchronizer flops, the edge flop, the counter, good_cnt, period_meas, locked, lost and err_cnt SHALL clear to 0 and the state SHALL be IDLE; a reset mid-LOCKED produces no lost pulse.

Configuration
REQ-027 With CLK_COPY_MON_ERRCNT_EN defined, err_cnt SHALL count bad events and timeouts in ACQ and LOCKED, saturating at 255, cleared only by reset; without it, the port and its logic SHALL be absent.

Structure
REQ-028 Package clk_copy_mon_pkg SHALL hold the state enum and the constant CNT_W=8.
REQ-029 The synchronizer SHALL be a sub-module, sync_cell, parameterised by depth.

Verification (defaults, SYNC_STAGES=2)
REQ-030 enable=1 with clk_copy_in toggling every 4 clk -> period_meas=4, locked rises 1 cycle after the 9th synced edge.
REQ-031 Locked, then toggling stops -> lost pulses 1 cycle and locked=0 when the counter reaches 16; state returns to ACQ.
REQ-032 Locked, then one interval of 6 clk -> period_meas=6, lost pulse; intervals of 3 and 5 do not break lock.
REQ-033 Locked, then enable dropped -> locked=0 next cycle, no lost pulse; re-enable needs 9 edges to relock.
REQ-034 rst_n asserted while locked -> all outputs 0 immediately; with the macro defined, err_cnt of 3 after three bad intervals returns to 0.
